// File: rtl/ins_fetch.sv
// Instruction fetch/issue stage: reads a program from synchronous IMEM,
// buffers words in a small FIFO and issues them under valid/ready.
module ins_fetch #(
   parameter int unsigned IMEM_AW    = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               flush,
   input  logic [IMEM_AW-1:0] base_pc,
   input  logic [IMEM_AW:0]   ins_count,
   output logic               imem_rd_en,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [36:0]        imem_rdata,
   output logic [4:0]         op_code,
   output logic [15:0]        op_addr1,
   output logic [15:0]        op_addr2,
   output logic               ins_valid,
   input  logic               ins_ready,
   output logic               busy,
   output logic               done
);

   localparam int unsigned DW = 37;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned NW = IMEM_AW + 1;
   localparam logic [4:0]  END_OP = 5'b11111;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t              state;
   state_t              state_nx;
   logic [IMEM_AW-1:0]  pc;
   logic [NW-1:0]       cnt;
   logic [NW-1:0]       issued;
   logic                inflight;
   logic [DW-1:0]       mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       fifo_count;
   logic                ret_end;
   logic                push;
   logic                pop;
   logic                rd_en;
   logic                done_d;
   logic                busy_d;
   logic [DW-1:0]       head;

   // A returning END word stops fetching and is never buffered
   assign ret_end = inflight && (imem_rdata[36:32] == END_OP);
   assign push    = inflight && !ret_end && !flush;
   assign pop     = ins_valid && ins_ready && !flush;

   // Read credit counts the in-flight word; same-cycle pops are not credited
   assign rd_en = (state == S_FETCH) && !flush && !ret_end &&
                  ((CW+1)'(fifo_count) + (CW+1)'(inflight) < (CW+1)'(FIFO_DEPTH));

   assign imem_rd_en = rd_en;
   assign imem_addr  = pc;

   // Head presentation, zeroed when the FIFO is empty
   assign ins_valid = (fifo_count != '0);
   assign head      = mem[rd_ptr];
   assign op_code   = ins_valid ? head[36:32] : 5'd0;
   assign op_addr1  = ins_valid ? head[31:16] : 16'd0;
   assign op_addr2  = ins_valid ? head[15:0]  : 16'd0;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // Next-state logic; flush overrides every transition
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) state_nx = (ins_count == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH: begin
            if (ret_end || (rd_en && (issued + NW'(1) == cnt))) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if ((fifo_count == '0) && !inflight) state_nx = S_DONE;
         end
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (flush) state_nx = S_IDLE;
   end

   // Output decode from the next state so done/busy come straight from flops
   always_comb begin
      done_d = 1'b0;
      busy_d = 1'b0;
      if (state_nx == S_DONE) done_d = 1'b1;
      if (state_nx != S_IDLE) busy_d = 1'b1;
   end

   // Registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done <= 1'b0;
         busy <= 1'b0;
      end else begin
         done <= done_d;
         busy <= busy_d;
      end
   end

   // Program counter, fetch counter and read-in-flight tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= '0;
         cnt      <= '0;
         issued   <= '0;
         inflight <= 1'b0;
      end else if (flush) begin
         inflight <= 1'b0;
      end else begin
         inflight <= rd_en;
         if ((state == S_IDLE) && start) begin
            pc     <= base_pc;
            cnt    <= ins_count;
            issued <= '0;
         end else if (rd_en) begin
            pc     <= pc + IMEM_AW'(1);
            issued <= issued + NW'(1);
         end
      end
   end

   // Issue FIFO; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= imem_rdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      fifo_count <= fifo_count + CW'(1);
         else if (pop && !push) fifo_count <= fifo_count - CW'(1);
      end
   end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch with a synchronous instruction memory model.
module tb_ins_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [7:0]  base_pc;
   logic [8:0]  ins_count;
   logic        imem_rd_en;
   logic [7:0]  imem_addr;
   logic [36:0] imem_rdata;
   logic [4:0]  op_code;
   logic [15:0] op_addr1;
   logic [15:0] op_addr2;
   logic        ins_valid;
   logic        ins_ready;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [36:0] mem [256];
   logic [7:0]  rd_q [$];
   logic [36:0] acc_q [$];
   int          done_cnt = 0;

   ins_fetch #(.IMEM_AW(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush),
      .base_pc(base_pc), .ins_count(ins_count),
      .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .op_code(op_code), .op_addr1(op_addr1), .op_addr2(op_addr2),
      .ins_valid(ins_valid), .ins_ready(ins_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous memory with one-cycle read latency
   always @(posedge clk) begin
      if (imem_rd_en) imem_rdata <= mem[imem_addr];
   end

   // Log issued reads, accepted instructions and done pulses
   always @(posedge clk) begin
      if (rst) begin
         if (imem_rd_en) rd_q.push_back(imem_addr);
         if (ins_valid && ins_ready) acc_q.push_back({op_code, op_addr1, op_addr2});
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   function automatic logic [36:0] word_of(input int a);
      logic [4:0]  op;
      logic [15:0] a1;
      logic [15:0] a2;
      op = 5'(a % 16);
      a1 = 16'(a * 3 + 256);
      a2 = 16'(a) ^ 16'h5A5A;
      return {op, a1, a2};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (done) begin
            seen = 1;
            break;
         end
      end
      chk(tag, 64'(seen), 64'd1);
      cyc();
      cyc();
   endtask

   function automatic logic [36:0] head();
      return {op_code, op_addr1, op_addr2};
   endfunction

   initial begin
      int d0;
      for (int i = 0; i < 256; i++) mem[i] = word_of(i);
      imem_rdata = '0;
      rst = 1'b0; start = 1'b0; flush = 1'b0;
      base_pc = '0; ins_count = '0; ins_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_outputs", {imem_rd_en, imem_addr, head(), ins_valid, busy, done}, 64'd0);
      rst = 1'b1;
      cyc();

      // Basic program
      rd_q.delete(); acc_q.delete();
      base_pc = 8'h10; ins_count = 9'd3; ins_ready = 1'b1; start = 1'b1;
      cyc(); start = 1'b0;
      chk("basic_c1_rd", {imem_rd_en, imem_addr, ins_valid, busy}, {1'b1, 8'h10, 1'b0, 1'b1});
      cyc();
      chk("basic_c2_rd", {imem_rd_en, imem_addr, ins_valid}, {1'b1, 8'h11, 1'b0});
      cyc();
      chk("basic_c3_head", {ins_valid, head()}, {1'b1, word_of(16'h10)});
      cyc();
      chk("basic_c4_head", {ins_valid, head()}, {1'b1, word_of(16'h11)});
      cyc();
      chk("basic_c5_head", {ins_valid, head()}, {1'b1, word_of(16'h12)});
      cyc();
      chk("basic_c6_empty", {ins_valid, done, busy}, {1'b0, 1'b0, 1'b1});
      cyc();
      chk("basic_c7_done", {done, busy}, {1'b1, 1'b1});
      cyc();
      chk("basic_c8_idle", {done, busy}, {1'b0, 1'b0});
      chk("basic_nreads", 64'(rd_q.size()), 64'd3);
      for (int i = 0; i < rd_q.size(); i++) chk("basic_raddr", 64'(rd_q[i]), 64'(8'h10 + i));

      // Zero-length program
      rd_q.delete();
      ins_count = 9'd0; start = 1'b1;
      chk("zero_c0_rd", 64'(imem_rd_en), 64'd0);
      cyc(); start = 1'b0;
      chk("zero_c1_done", {done, busy, imem_rd_en}, {1'b1, 1'b1, 1'b0});
      cyc();
      chk("zero_c2_idle", {done, busy}, {1'b0, 1'b0});
      chk("zero_nreads", 64'(rd_q.size()), 64'd0);

      // Backpressure, with a start while busy that must be ignored
      rd_q.delete(); acc_q.delete();
      base_pc = 8'h40; ins_count = 9'd8; ins_ready = 1'b0; start = 1'b1;
      cyc(); start = 1'b0;
      cyc(); cyc();
      base_pc = 8'hA0; ins_count = 9'd2; start = 1'b1;
      cyc(); start = 1'b0;
      repeat (6) cyc();
      chk("bp_nreads", 64'(rd_q.size()), 64'd4);
      chk("bp_stalled", {imem_rd_en, ins_valid, head()}, {1'b0, 1'b1, word_of(16'h40)});
      ins_ready = 1'b1;
      wait_done("bp_done", 60);
      chk("bp_nacc", 64'(acc_q.size()), 64'd8);
      for (int i = 0; i < acc_q.size(); i++) chk("bp_order", 64'(acc_q[i]), 64'(word_of(16'h40 + i)));
      for (int i = 0; i < rd_q.size(); i++) chk("bp_raddr", 64'(rd_q[i]), 64'(8'h40 + i));

      // END opcode at word 2 of 6
      rd_q.delete(); acc_q.delete();
      mem[8'h82] = {5'b11111, 32'hDEADBEEF};
      base_pc = 8'h80; ins_count = 9'd6; start = 1'b1;
      cyc(); start = 1'b0;
      wait_done("end_done", 40);
      chk("end_nacc", 64'(acc_q.size()), 64'd2);
      for (int i = 0; i < acc_q.size(); i++) chk("end_order", 64'(acc_q[i]), 64'(word_of(16'h80 + i)));
      chk("end_nreads", 64'(rd_q.size()), 64'd3);
      mem[8'h82] = word_of(16'h82);

      // Address wrap
      rd_q.delete(); acc_q.delete();
      base_pc = 8'hFE; ins_count = 9'd4; start = 1'b1;
      cyc(); start = 1'b0;
      wait_done("wrap_done", 40);
      chk("wrap_nreads", 64'(rd_q.size()), 64'd4);
      if (rd_q.size() == 4) begin
         chk("wrap_a0", 64'(rd_q[0]), 64'h0FE);
         chk("wrap_a1", 64'(rd_q[1]), 64'h0FF);
         chk("wrap_a2", 64'(rd_q[2]), 64'h000);
         chk("wrap_a3", 64'(rd_q[3]), 64'h001);
      end
      chk("wrap_acc2", 64'(acc_q.size() > 2 ? acc_q[2] : 37'd0), 64'(word_of(0)));

      // Flush with three buffered words and a read in flight
      ins_ready = 1'b0;
      base_pc = 8'h20; ins_count = 9'd8; start = 1'b1;
      cyc(); start = 1'b0;
      repeat (4) cyc();
      chk("flush_pre", {ins_valid, busy, head()}, {1'b1, 1'b1, word_of(16'h20)});
      d0 = done_cnt;
      flush = 1'b1;
      cyc(); flush = 1'b0;
      chk("flush_next", {ins_valid, busy, done}, {1'b0, 1'b0, 1'b0});
      repeat (3) cyc();
      chk("flush_nodone", 64'(done_cnt - d0), 64'd0);
      chk("flush_quiet", {ins_valid, busy, imem_rd_en}, {1'b0, 1'b0, 1'b0});

      // Restart after flush behaves like the basic program
      acc_q.delete();
      ins_ready = 1'b1; base_pc = 8'h10; ins_count = 9'd3; start = 1'b1;
      cyc(); start = 1'b0;
      chk("rs_c1_rd", {imem_rd_en, imem_addr}, {1'b1, 8'h10});
      cyc();
      chk("rs_c2_novalid", 64'(ins_valid), 64'd0);
      cyc();
      chk("rs_c3_head", {ins_valid, head()}, {1'b1, word_of(16'h10)});
      wait_done("rs_done", 20);
      chk("rs_nacc", 64'(acc_q.size()), 64'd3);

      // Asynchronous reset in DRAIN
      ins_ready = 1'b0; base_pc = 8'h30; ins_count = 9'd3; start = 1'b1;
      cyc(); start = 1'b0;
      repeat (3) cyc();
      chk("ar_pre", {busy, ins_valid}, {1'b1, 1'b1});
      rst = 1'b0;
      #1;
      chk("ar_outputs", {imem_rd_en, imem_addr, head(), ins_valid, busy, done}, 64'd0);
      cyc();
      rst = 1'b1;
      cyc();
      chk("ar_after", {ins_valid, busy, done}, {1'b0, 1'b0, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch and issue stage of the accelerator, placed directly upstream of the instruction decoder. On `start` it reads a program of packed instruction words from a synchronous instruction memory, buffers them in a small FIFO, and presents one instruction per cycle as `{op_code, op_addr1, op_addr2}` under a valid/ready handshake. A program ends after `ins_count` words or at an END opcode (5'b11111), whichever comes first. The block then pulses `done`.

## Interface

Parameters:
- `IMEM_AW`, 8: instruction memory address width.
- `FIFO_DEPTH`, 4: issue FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: begin a program; sampled only in IDLE.
- `flush`, input, 1: synchronous abort.
- `base_pc`, input, IMEM_AW: first instruction address; captured on accepted `start`.
- `ins_count`, input, IMEM_AW+1: maximum number of words to fetch; captured on accepted `start`.
- `imem_rd_en`, output, 1: instruction memory read strobe.
- `imem_addr`, output, IMEM_AW: instruction memory read address.
- `imem_rdata`, input, 37: read data, valid the cycle after `imem_rd_en`. Layout: [36:32] op_code, [31:16] op_addr1, [15:0] op_addr2.
- `op_code`, output, 5: head instruction opcode.
- `op_addr1`, output, 16: head read address.
- `op_addr2`, output, 16: head write address.
- `ins_valid`, output, 1: head instruction valid.
- `ins_ready`, input, 1: decoder accepts the head.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse at program completion.

## Operation

State machine:
- **IDLE**: accepts `start` and captures `base_pc` and `ins_count`. Goes to FETCH, or to DONE if `ins_count` is 0.
- **FETCH**: issues reads. Goes to DRAIN when the fetched count reaches `ins_count` or when an END word returns.
- **DRAIN**: no new reads. Waits until the FIFO is empty and no read is in flight, then goes to DONE.
- **DONE**: asserts `done` for one cycle, then returns to IDLE.

Read issue:
- `imem_rd_en` is combinational. It is high only in FETCH, when (fifo_count + inflight) < FIFO_DEPTH, and when no END word is returning this cycle.
- Pops in the same cycle are not credited.
- `imem_addr` starts at `base_pc` and increments after each issued read. It wraps modulo 2^IMEM_AW.
- inflight is 0 or 1, because read latency is exactly 1.

Returned data:
- Every word returned in FETCH is pushed into the FIFO, except an END word.
- An END word is not pushed. It forces a transition to DRAIN.
- Any data returning after END is discarded.

Issue:
- `ins_valid` = FIFO not empty.
- `op_code`, `op_addr1` and `op_addr2` show the head entry while `ins_valid` is high, and all zero otherwise.
- The head is popped when `ins_valid && ins_ready`.
- Push and pop in the same cycle are allowed, including when the FIFO is full. The count is then unchanged.

Flush:
- Clears the FIFO, drops any in-flight return, and goes to IDLE the next cycle.
- No `done` pulse is generated.
- `flush` has priority over `start` and over push/pop.

`start` while busy is ignored.

Reset values: `imem_rd_en`=0, `imem_addr`=0, `op_code`=0, `op_addr1`=0, `op_addr2`=0, `ins_valid`=0, `busy`=0, `done`=0. FIFO is empty and state is IDLE. Reset mid-program discards everything immediately.

## Timing

- `start` sampled at edge E0. `imem_rd_en` is high with `imem_addr`=`base_pc` in the following cycle (C1).
- Data returns in C2 and is pushed at the end of C2. `ins_valid` is high in C3. Latency from `start` to first `ins_valid` is 3 cycles.
- With `ins_ready` held high, sustained throughput is 1 instruction per cycle.
- Backpressure: with `ins_ready` low, reads stop once fifo_count + inflight = FIFO_DEPTH. No data is lost.
- `done` is asserted the cycle after DRAIN sees the FIFO empty with no read in flight. `busy` falls in the cycle after `done`.
- `ins_count`=0: `done` is asserted in the cycle after E0, and no read is issued.

## Test plan

- **Basic program:** `base_pc`=0x10, `ins_count`=3, memory holds I0..I2, `ins_ready`=1.
  - Expect reads at 0x10..0x12.
  - Expect I0 on the outputs with `ins_valid` 3 cycles after `start`, followed by I1 and I2 on consecutive cycles.
  - Expect `done` 1 cycle after the FIFO empties.
- **Backpressure:** `ins_count`=8, `ins_ready`=0 for 10 cycles.
  - Expect exactly 4 reads, then `imem_rd_en` low.
  - After `ins_ready` rises, expect all 8 instructions delivered in order with none duplicated.
- **END opcode:** word 2 of 6 has op_code 5'b11111.
  - Expect only words 0 and 1 issued.
  - Expect any read returning after END to be discarded, then `done`.
- **Wrap:** `IMEM_AW`=8, `base_pc`=0xFE, `ins_count`=4.
  - Expect addresses 0xFE, 0xFF, 0x00, 0x01.
- **Flush mid-program:** assert `flush` while the FIFO holds 3 entries and a read is in flight.
  - Next cycle: `ins_valid`=0, `busy`=0, no `done` pulse.
  - A new `start` behaves as in the basic program test.
- **Edge cases:**
  - `ins_count`=0: expect `done` 1 cycle after `start` and no `imem_rd_en`.
  - `start` while busy: ignored.
  - Async reset mid-DRAIN: all outputs at their reset values.
